// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: steps the 10-LED bank through four blink patterns.
// A phase accumulator sets the step rate from SW, and a debounced KEY press
// advances the mode.
// Ports: CLOCK_50 clock, reset async active-high, SW rate/freeze select,
//        KEY active-low button, LEDR pattern, mode current mode,
//        step_tick one-cycle pulse on each new pattern step.
module led_pattern_sequencer #(
   parameter int TICK_LIMIT = 50000000,
   parameter int DEBOUNCE   = 1000000,
   parameter int ACC_W      = 27
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [9:0] SW,
   input  logic       KEY,
   output logic [9:0] LEDR,
   output logic [1:0] mode,
   output logic       step_tick
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {
      ALT   = 2'd0,
      CHASE = 2'd1,
      FILL  = 2'd2,
      BLINK = 2'd3
   } mode_t;

   logic [6:0]       step_q, step_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             sync1_q, sync2_q;
   logic             db_q, db_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             next_q, next_d;
   mode_t            mode_q, mode_d;
   logic [9:0]       led_q, led_d;
   logic             tick_q, tick_d;

   logic [ACC_W-1:0] acc_sum;
   logic             unused_sw;

   assign unused_sw = ^SW[8:7];

   function automatic logic [9:0] init_pat(input mode_t m);
      logic [9:0] p;
      case (m)
         ALT:     p = 10'h2AA;
         CHASE:   p = 10'h001;
         default: p = 10'h000;
      endcase
      return p;
   endfunction

   function automatic logic [9:0] step_pat(input mode_t m,
                                           input logic [9:0] v);
      logic [9:0] p;
      case (m)
         CHASE:   p = {v[8:0], v[9]};
         FILL:    p = (v == 10'h3FF) ? 10'h000 : {v[8:0], 1'b1};
         default: p = ~v;
      endcase
      return p;
   endfunction

   // Rate select: lowest-numbered set switch wins; SW[9] freezes.
   always_comb begin
      step_d = 7'd0;
      if (!SW[9]) begin
         if      (SW[0]) step_d = 7'd1;
         else if (SW[1]) step_d = 7'd2;
         else if (SW[2]) step_d = 7'd5;
         else if (SW[3]) step_d = 7'd10;
         else if (SW[4]) step_d = 7'd20;
         else if (SW[5]) step_d = 7'd50;
         else if (SW[6]) step_d = 7'd100;
      end
   end

   // Debounce: count while the synced level disagrees with the accepted
   // level; a press is reported as a registered pulse one edge later.
   always_comb begin
      db_d   = db_q;
      cnt_d  = '0;
      next_d = 1'b0;
      if (sync2_q != db_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == CNT_W'(DEBOUNCE)) begin
            cnt_d  = '0;
            db_d   = sync2_q;
            next_d = db_q;
         end
      end
   end

   assign acc_sum = acc_q + ACC_W'(step_q);

   // Mode change outranks a coincident step: acc restarts from zero.
   always_comb begin
      mode_d = mode_q;
      led_d  = led_q;
      acc_d  = acc_q;
      tick_d = 1'b0;
      if (next_q) begin
         mode_d = mode_t'(mode_q + 2'd1);
         led_d  = init_pat(mode_d);
         acc_d  = '0;
      end else if (step_q != 7'd0) begin
         if (acc_sum >= ACC_W'(TICK_LIMIT)) begin
            acc_d  = acc_sum - ACC_W'(TICK_LIMIT);
            led_d  = step_pat(mode_q, led_q);
            tick_d = 1'b1;
         end else begin
            acc_d = acc_sum;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         step_q  <= '0;
         acc_q   <= '0;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         db_q    <= 1'b1;
         cnt_q   <= '0;
         next_q  <= 1'b0;
         mode_q  <= ALT;
         led_q   <= 10'h2AA;
         tick_q  <= 1'b0;
      end else begin
         step_q  <= step_d;
         acc_q   <= acc_d;
         sync1_q <= KEY;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         next_q  <= next_d;
         mode_q  <= mode_d;
         led_q   <= led_d;
         tick_q  <= tick_d;
      end
   end

   assign LEDR      = led_q;
   assign mode      = mode_q;
   assign step_tick = tick_q;

endmodule
